// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform generator with a quarter-wave sine
// table, square/triangle/sawtooth modes and a 3-stage valid-qualified pipeline.
// Stage 1 samples the phase, stage 2 folds the quadrant and reads the table,
// and stage 3 selects the waveform and drives the output.
module dds_wave_gen #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 6,
  parameter int AMP_W   = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               sync_in,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic [PHASE_W-1:0] phase_off_in,
  input  logic [1:0]         mode_in,
  output logic [AMP_W-1:0]   amp_out,
  output logic               valid_out
);

  localparam int Q = 1 << (PHASE_W - 2);
  localparam logic [AMP_W-1:0]   MID   = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [AMP_W-1:0]   FULL  = {AMP_W{1'b1}};
  localparam logic [PHASE_W-2:0] Q_IDX = {1'b1, {(PHASE_W-2){1'b0}}};
  localparam logic [1:0] MODE_SINE = 2'd0;
  localparam logic [1:0] MODE_SQR  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_SAW  = 2'd3;
  localparam real PI = 3.14159265358979323846;

  // Keep the top AMP_W bits of raw, zero-filling on the right when raw is narrower.
  function automatic logic [AMP_W-1:0] scale_raw(input logic [PHASE_W-1:0] raw);
    logic [AMP_W+PHASE_W-1:0] t;
    t = {raw, {AMP_W{1'b0}}};
    return t[AMP_W+PHASE_W-1 -: AMP_W];
  endfunction

  // Quarter-wave table q(k) = round((MID-1)*sin(pi/2*k/Q)), computed at elaboration.
  logic [AMP_W-1:0] w_qtab [0:Q];
  for (genvar k = 0; k <= Q; k++) begin : g_tab
    localparam real ANG = PI / 2.0 * real'(k) / real'(Q);
    localparam int  QV  = $rtoi(real'((1 << (AMP_W - 1)) - 1) * $sin(ANG) + 0.5);
    assign w_qtab[k] = QV[AMP_W-1:0];
  end

  // Stage 1 registers
  logic [ACC_W-1:0]   r_acc;
  logic [PHASE_W-1:0] r_s1_p;
  logic [1:0]         r_s1_mode;
  logic               r_s1_vld;
  logic [PHASE_W-1:0] w_p;

  assign w_p = r_acc[ACC_W-1 -: PHASE_W] + phase_off_in;

  // Stage 1: phase accumulate and sample the offset phase on enabled cycles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_acc     <= {ACC_W{1'b0}};
      r_s1_p    <= {PHASE_W{1'b0}};
      r_s1_mode <= 2'd0;
      r_s1_vld  <= 1'b0;
    end else if (sync_in) begin
      r_acc    <= {ACC_W{1'b0}};
      r_s1_vld <= 1'b0;
    end else if (en_in) begin
      r_acc     <= r_acc + ftw_in;
      r_s1_p    <= w_p;
      r_s1_mode <= mode_in;
      r_s1_vld  <= 1'b1;
    end else begin
      r_s1_vld <= 1'b0;
    end
  end

  // Stage 2 registers
  logic [PHASE_W-2:0] w_idx;
  logic [AMP_W-1:0]   r_s2_q;
  logic [PHASE_W-1:0] r_s2_p;
  logic [1:0]         r_s2_mode;
  logic               r_s2_vld;

  // Fold the quadrant: odd quadrants read the table mirrored (Q - i).
  always_comb begin
    w_idx = {1'b0, r_s1_p[PHASE_W-3:0]};
    if (r_s1_p[PHASE_W-2]) begin
      w_idx = Q_IDX - {1'b0, r_s1_p[PHASE_W-3:0]};
    end else begin
      w_idx = {1'b0, r_s1_p[PHASE_W-3:0]};
    end
  end

  // Stage 2: table read; phase, mode and valid travel alongside.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s2_q    <= {AMP_W{1'b0}};
      r_s2_p    <= {PHASE_W{1'b0}};
      r_s2_mode <= 2'd0;
      r_s2_vld  <= 1'b0;
    end else begin
      r_s2_q    <= w_qtab[w_idx];
      r_s2_p    <= r_s1_p;
      r_s2_mode <= r_s1_mode;
      r_s2_vld  <= r_s1_vld;
    end
  end

  // Stage 3 waveform selection
  logic [AMP_W-1:0]   w_amp;
  logic [PHASE_W-1:0] w_tri_u;

  assign w_tri_u = {r_s2_p[PHASE_W-2:0], 1'b0};

  // Build the sample for the selected mode; lower half-wave of sine is mirrored below MID.
  always_comb begin
    w_amp = MID;
    case (r_s2_mode)
      MODE_SINE: w_amp = r_s2_p[PHASE_W-1] ? (MID - r_s2_q) : (MID + r_s2_q);
      MODE_SQR:  w_amp = r_s2_p[PHASE_W-1] ? {AMP_W{1'b0}} : FULL;
      MODE_TRI:  w_amp = scale_raw(r_s2_p[PHASE_W-1] ? ~w_tri_u : w_tri_u);
      MODE_SAW:  w_amp = scale_raw(r_s2_p);
      default:   w_amp = MID;
    endcase
  end

  // Stage 3: output register; amp_out holds between valid samples.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      amp_out   <= MID;
      valid_out <= 1'b0;
    end else begin
      valid_out <= r_s2_vld;
      if (r_s2_vld) begin
        amp_out <= w_amp;
      end else begin
        amp_out <= amp_out;
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen (default parameters) against a
// behavioural model built from phase arithmetic and real-valued sine.
module tb_dds_wave_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        en_in = 1'b0;
  logic        sync_in = 1'b0;
  logic [23:0] ftw_in = 24'd0;
  logic [5:0]  phase_off_in = 6'd0;
  logic [1:0]  mode_in = 2'd0;
  logic [7:0]  amp_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  // model state
  longint m_acc;
  bit     d1_v, d2_v, out_v;
  int     d1_a, d2_a, out_a;
  logic [7:0] samples[$];

  dds_wave_gen dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .sync_in(sync_in),
    .ftw_in(ftw_in), .phase_off_in(phase_off_in), .mode_in(mode_in),
    .amp_out(amp_out), .valid_out(valid_out)
  );

  always #5 clk_in = ~clk_in;

  // Ideal waveform value for a 64-point phase p with 8-bit offset-binary output.
  function automatic int model_wave(input int mode, input int p);
    real s;
    int  m;
    case (mode)
      0: begin
        s = 127.0 * $sin(2.0 * PI * real'(p) / 64.0);
        m = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
        return 128 + m;
      end
      1: return (p < 32) ? 255 : 0;
      2: return (p < 32) ? p * 8 : (127 - 2 * p) * 4;
      default: return p * 4;
    endcase
  endfunction

  function automatic void model_reset();
    m_acc = 0;
    d1_v = 0; d2_v = 0; out_v = 0;
    d1_a = 128; d2_a = 128; out_a = 128;
  endfunction

  // One clock: drive inputs, advance the model, compare outputs 1 time unit after the edge.
  task automatic step(input logic en, input logic sy);
    int p;
    en_in = en;
    sync_in = sy;
    @(posedge clk_in);
    out_v = d2_v;
    if (d2_v) out_a = d2_a;
    d2_v = d1_v;
    d2_a = d1_a;
    if (sy) begin
      m_acc = 0;
      d1_v = 0;
    end else if (en) begin
      p = int'(((m_acc >> 18) + longint'(phase_off_in)) % 64);
      d1_v = 1;
      d1_a = model_wave(int'(mode_in), p);
      m_acc = (m_acc + longint'(ftw_in)) % (longint'(1) << 24);
    end else begin
      d1_v = 0;
    end
    #1;
    checks++;
    if (valid_out !== out_v)
      $display("FAIL valid_out t=%0t got %b expected %b", $time, valid_out, out_v);
    if (valid_out !== out_v) errors++;
    checks++;
    if (amp_out !== 8'(out_a)) begin
      errors++;
      $display("FAIL amp_out t=%0t got %0d expected %0d", $time, amp_out, out_a);
    end
    if (valid_out === 1'b1) samples.push_back(amp_out);
  endtask

  task automatic run_wave(input logic [1:0] mode, input int n);
    mode_in = mode;
    ftw_in = 24'd1 << 18;
    phase_off_in = 6'd0;
    samples.delete();
    step(1'b0, 1'b1);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    model_reset();
    #12;
    checks++;
    if (amp_out !== 8'd128 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state amp=%0d valid=%b expected 128/0", amp_out, valid_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_sine();
    int idx[6] = '{1, 3, 16, 32, 48, 64};
    int exp[6] = '{140, 165, 255, 128, 1, 128};
    run_wave(2'd0, 66);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (samples.size() <= idx[k] || samples[idx[k]] !== 8'(exp[k])) begin
        errors++;
        $display("FAIL sine_sample_%0d got %0d expected %0d", idx[k],
                 (samples.size() > idx[k]) ? int'(samples[idx[k]]) : -1, exp[k]);
      end
    end
  endtask

  task automatic test_square();
    run_wave(2'd1, 66);
    for (int k = 0; k < 65; k++) begin
      checks++;
      if (samples.size() <= k || samples[k] !== (((k % 64) < 32) ? 8'd255 : 8'd0)) begin
        errors++;
        $display("FAIL square_sample_%0d", k);
      end
    end
  endtask

  task automatic test_saw();
    run_wave(2'd3, 66);
    for (int k = 0; k < 65; k++) begin
      checks++;
      if (samples.size() <= k || samples[k] !== 8'((k % 64) * 4)) begin
        errors++;
        $display("FAIL saw_sample_%0d expected %0d", k, (k % 64) * 4);
      end
    end
  endtask

  task automatic test_triangle();
    int idx[5] = '{1, 31, 32, 33, 63};
    int exp[5] = '{8, 248, 252, 244, 4};
    run_wave(2'd2, 66);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (samples.size() <= idx[k] || samples[idx[k]] !== 8'(exp[k])) begin
        errors++;
        $display("FAIL tri_sample_%0d expected %0d", idx[k], exp[k]);
      end
    end
  endtask

  task automatic test_offset_mode();
    mode_in = 2'd0;
    ftw_in = 24'd1 << 18;
    phase_off_in = 6'd16;
    samples.delete();
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    mode_in = 2'd3;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (samples.size() < 12 || samples[0] !== 8'd255 || samples[6] !== 8'(22 * 4)) begin
      errors++;
      $display("FAIL offset_mode first=%0d switched=%0d expected 255/88",
               (samples.size() > 0) ? int'(samples[0]) : -1,
               (samples.size() > 6) ? int'(samples[6]) : -1);
    end
    phase_off_in = 6'd0;
  endtask

  task automatic test_en_toggle();
    mode_in = 2'd3;
    ftw_in = 24'd1 << 18;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_sync_with_en();
    mode_in = 2'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    samples.delete();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (samples.size() < 3 || samples[samples.size()-1] !== 8'd128) begin
      errors++;
      $display("FAIL sync_with_en last sample %0d expected 128",
               (samples.size() > 0) ? int'(samples[samples.size()-1]) : -1);
    end
  endtask

  task automatic test_async_reset();
    mode_in = 2'd1;
    ftw_in = 24'h0ABCDE;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (amp_out !== 8'd128 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset amp=%0d valid=%b expected 128/0", amp_out, valid_out);
    end
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    mode_in = 2'd0;
    ftw_in = 24'd1 << 18;
    samples.delete();
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (samples.size() < 1 || samples[0] !== 8'd128) begin
      errors++;
      $display("FAIL restart_after_reset first=%0d expected 128",
               (samples.size() > 0) ? int'(samples[0]) : -1);
    end
  endtask

  task automatic test_random();
    logic e, s;
    for (int i = 0; i < 400; i++) begin
      ftw_in = 24'($urandom);
      phase_off_in = 6'($urandom);
      mode_in = 2'($urandom);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 19) == 0);
      step(e, s);
    end
    ftw_in = 24'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sine();
    test_square();
    test_saw();
    test_triangle();
    test_offset_mode();
    test_en_toggle();
    test_sync_with_en();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
